// File: rtl/digit_scan_display_pkg.sv
// Shared constants and types for the multiplexed 7-segment digit scanner.
package digit_scan_display_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int IDX_W      = 3;

  // Active-high glyphs, segment a in bit 0; index is the hex code (highest entry first).
  localparam logic [15:0][6:0] HEX_GLYPHS = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_MINUS = 7'h40;

  typedef struct packed {
    logic [NUM_DIGITS-1:0][3:0] codes;
    logic [NUM_DIGITS-1:0]      signPos;
  } digitSet_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             pendingValid;
  } scanDebug_t;

  function automatic logic [NUM_DIGITS-1:0] digitSelect(input logic [IDX_W-1:0] idx);
    return {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/digit_scan_display_if.sv
// Digit load strobe, display drive outputs and scanner debug state.
// load is a one-sided strobe: there is no ready, every cycle with load=1 is accepted.
interface digit_scan_display_if;
  import digit_scan_display_pkg::*;

  logic       load;
  logic [3:0] d1;
  logic [3:0] d2;
  logic [3:0] d3;
  logic [3:0] d4;
  logic [3:0] d5;
  logic [3:0] d6;
  logic [5:0] sign_pos;
  logic [5:0] an;
  logic [6:0] seg;
  logic       frame_start;
  scanDebug_t dbg;

  modport master (
    output load, d1, d2, d3, d4, d5, d6, sign_pos,
    input  an, seg, frame_start, dbg
  );

  modport slave (
    input  load, d1, d2, d3, d4, d5, d6, sign_pos,
    output an, seg, frame_start, dbg
  );
endinterface

// File: rtl/digit_scan_display_seg7_decode.sv
// Combinational digit-code to active-high segment pattern decoder.
module seg7_decode
  import digit_scan_display_pkg::*;
(
  input  logic [3:0] code,
  input  logic       is_sign,
  output logic [6:0] pattern
);

  // Sign positions only distinguish zero (blank) from anything else (minus).
  always_comb begin
    pattern = HEX_GLYPHS[code];
    if (is_sign) begin
      pattern = (code == 4'd0) ? SEG_BLANK : SEG_MINUS;
    end
  end

endmodule

// File: rtl/digit_scan_display.sv
// Six-digit scanned 7-segment driver with a shadow digit set committed at frame wrap.
module digit_scan_display
  import digit_scan_display_pkg::*;
#(
  parameter int PRESCALE       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  digit_scan_display_if.slave bus
);

  localparam int                    CNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{SEG_ACTIVE_LOW}};
  localparam logic [6:0]            SEG_OFF  = {7{SEG_ACTIVE_LOW}};

  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  digitSet_t        active;
  digitSet_t        pending;
  digitSet_t        liveSet;
  logic             pendingValid;
  logic             tick;
  logic             wrap;
  logic [3:0]       curCode;
  logic             curSign;
  logic [6:0]       pattern;

  always_comb begin
    liveSet.codes   = {bus.d6, bus.d5, bus.d4, bus.d3, bus.d2, bus.d1};
    liveSet.signPos = bus.sign_pos;
  end

  assign tick    = (cnt == CNT_LAST);
  assign wrap    = tick && (idx == IDX_LAST);
  assign curCode = active.codes[idx];
  assign curSign = active.signPos[idx];

  assign bus.dbg = '{idx: idx, pendingValid: pendingValid};

  seg7_decode u_decode (
    .code    (curCode),
    .is_sign (curSign),
    .pattern (pattern)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt             <= '0;
      idx             <= '0;
      active          <= '0;
      pending         <= '0;
      pendingValid    <= 1'b0;
      bus.an          <= AN_OFF;
      bus.seg         <= SEG_OFF;
      bus.frame_start <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end

      // Outputs follow idx by one cycle so anode and segments always change together.
      bus.an          <= SEG_ACTIVE_LOW ? ~digitSelect(idx) : digitSelect(idx);
      bus.seg         <= SEG_ACTIVE_LOW ? ~pattern : pattern;
      bus.frame_start <= wrap;

      if (bus.load) begin
        pending <= liveSet;
      end

      // A load landing on the wrap tick bypasses pending so it is never a frame late.
      if (wrap) begin
        pendingValid <= 1'b0;
        if (bus.load) begin
          active <= liveSet;
        end else if (pendingValid) begin
          active <= pending;
        end
      end else if (bus.load) begin
        pendingValid <= 1'b1;
      end
    end
  end

endmodule

// File: doc/digit_scan_display.md
Name: digit_scan_display

Overview:
- Consumes the six 4-bit digit codes produced by the operand-formatting stage: sign, tens and ones for each of X and Y.
- Drives a 6-digit multiplexed 7-segment display.
- Holds a tear-free shadow copy of the digits. New values are committed only at frame boundaries.
- Decodes each digit to a hex glyph, or to a minus sign/blank in sign positions, and scans the anodes at a prescaled rate.

Parameters:
- PRESCALE, default 50000: clock cycles per digit slot. Legal range is 1 or more; 1 means advance every cycle.
- SEG_ACTIVE_LOW, default 1: when 1, seg and an outputs are active-low; when 0, both are active-high.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- load, input, 1: capture d1..d6 and sign_pos this cycle.
- d1..d6, input, 4 each: digit codes. d1 is the leftmost digit, d6 the rightmost.
- sign_pos, input, 6: bit i=1 marks digit i+1 as a sign position. Normal use is 6'b001001, i.e. d1 and d4.
- an, output, 6: one-hot digit enable; an[0] drives the d1 position.
- seg, output, 7: segments; seg[0]=a through seg[6]=g.
- frame_start, output, 1: one-cycle pulse when the active digit set is (re)committed.

Behaviour:
- Reset (rst_n=0 at an edge):
  - prescale count=0, idx=0.
  - active and pending digit registers = 0; pending_valid=0.
  - an = all off (6'b111111 if active-low); seg = all off (7'h7F if active-low); frame_start=0.
  - Reset mid-operation discards any pending load.
- Prescaler: counts 0..PRESCALE-1. tick=1 when count==PRESCALE-1, and count then wraps to 0.
- Scan index: on tick, idx advances 0→1→…→5→0.
- Output latency: an and seg are registered from the current idx and active digits, one cycle after idx changes.
  - First cycle after reset release: an selects d1 on the next edge.
  - an pattern is ~(1<<idx) when active-low.
- Load capture: load=1 stores d1..d6 and sign_pos into pending and sets pending_valid. A later load before commit overwrites pending (last wins).
- Commit: on a tick with idx==5 (the wrap):
  - If load=1 in the same cycle, active ← the live inputs (bypass).
  - Else if pending_valid, active ← pending.
  - In both cases pending_valid is cleared.
  - frame_start=1 on the cycle after the wrap tick, whether or not new data was committed.
- Decode, non-sign position: hex glyph, active-high internal pattern:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- Decode, sign position: code 0 gives blank (00); any nonzero code gives minus (40, segment g only).
- Polarity: seg = SEG_ACTIVE_LOW ? ~pattern : pattern.
- Decoding is performed on the active registers only. Inputs are never displayed without a commit.
- Counter width is $clog2(PRESCALE) with a minimum of 1.

Decomposition:
- Shared header holds:
  - NUM_DIGITS=6.
  - The 16 hex glyph constants, SEG_BLANK=7'h00 and SEG_MINUS=7'h40.
- One sub-module, seg7_decode: combinational. Inputs are code[3:0] and is_sign; output is pattern[6:0], active-high.
- Polarity inversion and the anode register live in the top module.

Test Plan (PRESCALE=4, SEG_ACTIVE_LOW=1 unless noted):
1. Reset release → an=111111 and seg=7F during reset; first edge after release gives an=111110 and seg=~3F=40 (digit 0). Each digit slot lasts exactly 4 cycles; after slot 6 the scan returns to an[0].
2. Load d=1,0,5,0,0,9 with sign_pos=001001 mid-frame → old digits are shown until the wrap; frame_start pulses once; the next frame shows minus, 0, 5, blank, 0, 9 (seg 3F, 40, 12, 7F, 40, 10).
3. Two loads in one frame (first d3=3, then d3=A) → only A is displayed (seg ~77=08). A single commit occurs.
4. load asserted exactly on the idx==5 tick with d6=F → the new frame shows F in slot 6 immediately (seg ~71=0E); pending_valid=0 afterwards.
5. Load issued, then rst_n=0 for 1 cycle before the wrap → outputs return to reset values and the display shows all-zero digits, not the discarded load.
6. PRESCALE=1, SEG_ACTIVE_LOW=0 → an cycles 000001→000010→…→100000 on consecutive cycles; frame_start fires every 6 cycles; d3=8 gives seg=7F.
